// File: rtl/lane_pkg.sv
// Shared types for the lane packer: word/element shapes and the output FSM.
// The word shape matches the downstream packed-array consumer.
package lane_pkg;

   localparam int LANE_ELEM_W = 2;
   localparam int LANE_N_ELEM = 18;
   localparam int LANE_WORD_W = LANE_ELEM_W * LANE_N_ELEM;

   typedef logic [2:0][2:1][2:4][0:1] lane_word_t;
   typedef logic [LANE_ELEM_W-1:0]    lane_elem_t;

   typedef enum logic {
      ST_EMPTY,
      ST_HELD
   } lane_state_t;

   // True only when the parity is neither 0 nor 1, i.e. an X or Z bit is present
   function automatic logic elem_unknown(input lane_elem_t e);
      logic p;
      p = ^e;
      return (p !== 1'b0) && (p !== 1'b1);
   endfunction

endpackage

// File: rtl/lane_slot_acc.sv
// Element accumulator: fill counter, MSB-first slot writes and the sticky
// unknown flag, plus the close decision for the word being built.
module lane_slot_acc
   import lane_pkg::*;
#(
   parameter int ELEM_W = LANE_ELEM_W,
   parameter int N_ELEM = LANE_N_ELEM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic              flush,
   input  logic              room,
   input  logic [ELEM_W-1:0] elem,
   output logic              close,
   output logic              close_flush,
   output logic              close_pending,
   output lane_word_t        word_nxt,
   output logic              unk_nxt
);

   localparam int FILL_W = $clog2(N_ELEM + 1);
   localparam int WORD_W = ELEM_W * N_ELEM;

   logic [FILL_W-1:0] fill_q;
   logic [WORD_W-1:0] acc_q;
   logic [WORD_W-1:0] acc_nxt;
   logic              unk_q;
   logic              last;

   always_comb begin
      last          = (fill_q == FILL_W'(N_ELEM - 1));
      close_pending = last || flush;
      // A flush may only close when the output register can take the word
      close_flush   = flush && (fill_q != '0) && !accept && room;
      close         = (accept && last) || close_flush;
      acc_nxt       = acc_q;
      unk_nxt       = unk_q;
      if (accept) begin
         for (int i = 0; i < N_ELEM; i++) begin
            if (fill_q == FILL_W'(i)) begin
               acc_nxt[WORD_W-1-ELEM_W*i -: ELEM_W] = elem;
            end
         end
         unk_nxt = unk_q | elem_unknown(elem);
      end
      word_nxt = acc_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q <= '0;
         acc_q  <= '0;
         unk_q  <= 1'b0;
      end else if (close) begin
         fill_q <= '0;
         acc_q  <= '0;
         unk_q  <= 1'b0;
      end else if (accept) begin
         fill_q <= fill_q + 1'b1;
         acc_q  <= acc_nxt;
         unk_q  <= unk_nxt;
      end
   end

endmodule

// File: rtl/lane_packer.sv
// Packs 18 two-bit 4-state elements into one 36-bit word behind a one-entry
// output register with valid/ready on both sides and a wrapping word count.
module lane_packer
   import lane_pkg::*;
#(
   parameter int ELEM_W = 2,
   parameter int N_ELEM = 18,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ELEM_W-1:0] in_elem,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output lane_word_t        out_word,
   output logic              out_unknown,
   output logic              out_partial,
   output logic [CNT_W-1:0]  word_cnt
);

   lane_state_t state_q;
   lane_state_t state_d;

   logic       handoff;
   logic       room;
   logic       accept;
   logic       close;
   logic       close_flush;
   logic       close_pending;
   logic       unk_nxt;
   lane_word_t word_nxt;

   assign out_valid = (state_q == ST_HELD);
   assign handoff   = out_valid && out_ready;
   assign room      = !out_valid || out_ready;
   // Only the closing element stalls while a word is still held
   assign in_ready  = !(out_valid && !out_ready && close_pending);
   assign accept    = in_valid && in_ready;

   lane_slot_acc #(
      .ELEM_W (ELEM_W),
      .N_ELEM (N_ELEM)
   ) u_acc (
      .clk           (clk),
      .rst           (rst),
      .accept        (accept),
      .flush         (flush),
      .room          (room),
      .elem          (in_elem),
      .close         (close),
      .close_flush   (close_flush),
      .close_pending (close_pending),
      .word_nxt      (word_nxt),
      .unk_nxt       (unk_nxt)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (close) state_d = ST_HELD;
         ST_HELD:  if (handoff && !close) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_word    <= '0;
         out_unknown <= 1'b0;
         out_partial <= 1'b0;
      end else if (close) begin
         out_word    <= word_nxt;
         out_unknown <= unk_nxt;
         out_partial <= close_flush;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          word_cnt <= '0;
      else if (handoff) word_cnt <= word_cnt + 1'b1;
   end

endmodule
